shift_add_mul_ctrl: RTL and testbench

//  Sequencer that reuses one ADD_8 ripple-carry adder instance to run an unsigned

---
 rtl/shift_add_mul_ctrl.sv | 151 +++++++++++++++
 tb/tb_shift_add_mul_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ADD_8
// Brief    : Parameterised ripple-carry adder (SIZE bits, carry in/out).
// Ports    : i_a, i_b  - addends
//            i_ci      - carry in
//            o_sum     - SIZE-bit sum
//            o_co      - carry out of the most significant bit
// Revision : 1.0 - initial release
// ============================================================================
module ADD_8 #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] i_a,
    input  logic [SIZE-1:0] i_b,
    input  logic            i_ci,
    output logic [SIZE-1:0] o_sum,
    output logic            o_co
);

    logic [SIZE:0] w_c;

    assign w_c[0] = i_ci;

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_bit
        assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_co = w_c[SIZE];

endmodule

// ============================================================================
// Module   : shift_add_mul_ctrl
// Brief    : Unsigned SIZE x SIZE shift-and-add multiplier that reuses one
//            ADD_8 instance, one iteration per clock, SIZE iterations.
// Ports    : clk     - rising-edge clock
//            rst     - synchronous active-high reset
//            start   - request, only honoured in IDLE
//            a, b    - multiplicand / multiplier, captured on accepted start
//            busy    - high while iterating
//            done    - one-cycle pulse, product valid from this cycle
//            product - 2*SIZE-bit result, held until the next accepted start
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_mul_ctrl #(
    parameter int SIZE  = 8,
    parameter int CNT_W = $clog2(SIZE) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SIZE - 1);

    state_t              r_state;
    logic [SIZE-1:0]     r_mcand;
    logic [SIZE-1:0]     r_acc_hi;
    logic [SIZE-1:0]     r_acc_lo;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [2*SIZE-1:0]   r_product;

    logic [SIZE-1:0]     w_addend;
    logic [SIZE-1:0]     w_sum;
    logic                w_co;
    logic [2*SIZE-1:0]   w_shifted;

    // Add the multiplicand only when the current multiplier bit is set.
    assign w_addend = r_acc_lo[0] ? r_mcand : '0;

    ADD_8 #(
        .SIZE (SIZE)
    ) u_add (
        .i_a   (r_acc_hi),
        .i_b   (w_addend),
        .i_ci  (1'b0),
        .o_sum (w_sum),
        .o_co  (w_co)
    );

    // {co,sum,acc_lo} shifted right by one; the consumed multiplier bit drops
    // off the bottom and the carry is kept as the new top bit.
    assign w_shifted = {w_co, w_sum, r_acc_lo[SIZE-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= a;
                        r_acc_hi <= '0;
                        r_acc_lo <= b;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    {r_acc_hi, r_acc_lo} <= w_shifted;
                    r_cnt                <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_product <= w_shifted;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_mul_ctrl
// Brief    : Self-checking bench for shift_add_mul_ctrl (SIZE = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_mul_ctrl;

    localparam int SIZE = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic [SIZE-1:0]   a;
    logic [SIZE-1:0]   b;
    logic              busy;
    logic              done;
    logic [2*SIZE-1:0] product;

    int n_pass;
    int n_total;

    shift_add_mul_ctrl #(
        .SIZE (SIZE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helper: pulse start with (va,vb) from an idle DUT, then follow
    // the operation to its done pulse (bounded). Returns the number of cycles
    // from the accepting edge to done, busy-cycle count, overlap flag, product.
    task automatic do_mul(input logic [SIZE-1:0] va, input logic [SIZE-1:0] vb,
                          output int lat, output int nbusy, output bit both,
                          output logic [2*SIZE-1:0] res);
        lat   = 0;
        nbusy = 0;
        both  = 1'b0;
        @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~va;   // inputs may change freely after acceptance
        b     = ~vb;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy && done) both = 1'b1;
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                break;
            end
        end
        res = product;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'd5;
        b     = 8'd7;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_total++;
            if ({busy, done, product} !== {1'b0, 1'b0, 16'd0})
                $display("FAIL reset_outputs cyc%0d: got busy=%b done=%b product=%0d, want 0/0/0",
                         k, busy, done, product);
            else n_pass++;
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy, done, product} !== {1'b0, 1'b0, 16'd0})
            $display("FAIL reset_idle: got busy=%b done=%b product=%0d, want 0/0/0", busy, done, product);
        else n_pass++;
    endtask

    task automatic test_basic();
        int lat, nbusy;
        bit both;
        logic [15:0] res;
        do_mul(8'd13, 8'd11, lat, nbusy, both, res);
        n_total++;
        if (res !== 16'd143) $display("FAIL basic_product: got %0d, want 143", res);
        else n_pass++;
        n_total++;
        if (lat !== SIZE + 1) $display("FAIL basic_latency: got %0d, want %0d", lat, SIZE + 1);
        else n_pass++;
        n_total++;
        if (nbusy !== SIZE) $display("FAIL basic_busy_cycles: got %0d, want %0d", nbusy, SIZE);
        else n_pass++;
        n_total++;
        if (both !== 1'b0) $display("FAIL basic_busy_done_overlap: got %b, want 0", both);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++;
            if ({busy, done, product} !== {1'b0, 1'b0, 16'd143})
                $display("FAIL basic_hold cyc%0d: got busy=%b done=%b product=%0d, want 0/0/143",
                         k, busy, done, product);
            else n_pass++;
        end
    endtask

    task automatic test_corners();
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic [15:0] ve [3];
        int lat, nbusy;
        bit both;
        logic [15:0] res;
        va[0] = 8'd255; vb[0] = 8'd255; ve[0] = 16'hFE01;
        va[1] = 8'd0;   vb[1] = 8'd200; ve[1] = 16'd0;
        va[2] = 8'd1;   vb[2] = 8'd255; ve[2] = 16'd255;
        for (int i = 0; i < 3; i++) begin
            do_mul(va[i], vb[i], lat, nbusy, both, res);
            n_total++;
            if (res !== ve[i] || lat !== SIZE + 1)
                $display("FAIL corner_%0dx%0d: got product=%0d lat=%0d, want %0d lat=%0d",
                         va[i], vb[i], res, lat, ve[i], SIZE + 1);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int          at [3];
        logic [15:0] pr [3];
        int          nd;
        nd = 0;
        @(negedge clk);
        a     = 8'd3;
        b     = 8'd5;
        start = 1'b1;
        // Accepting edge is the next posedge; negedge n is cycle N+n.
        for (int n = 1; n <= 29; n++) begin
            @(negedge clk);
            if (n == 3) a = 8'd7;
            if (done) begin
                if (nd < 3) begin
                    at[nd] = n;
                    pr[nd] = product;
                end
                nd++;
            end
        end
        start = 1'b0;
        n_total++;
        if (nd !== 3) $display("FAIL b2b_done_count: got %0d, want 3", nd);
        else n_pass++;
        if (nd >= 3) begin
            n_total++;
            if (at[0] !== 9 || at[1] !== 19 || at[2] !== 29)
                $display("FAIL b2b_done_cycles: got %0d,%0d,%0d, want 9,19,29", at[0], at[1], at[2]);
            else n_pass++;
            n_total++;
            if (pr[0] !== 16'd15) $display("FAIL b2b_first_product: got %0d, want 15", pr[0]);
            else n_pass++;
            n_total++;
            if (pr[1] !== 16'd35 || pr[2] !== 16'd35)
                $display("FAIL b2b_later_products: got %0d,%0d, want 35,35", pr[1], pr[2]);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL b2b_drained: got busy=%b, want 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int lat, nbusy;
        bit both;
        bit seen_done;
        logic [15:0] res;
        @(negedge clk);
        a     = 8'd100;
        b     = 8'd100;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 4; n++) @(negedge clk);
        n_total++;
        if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b, want 1", busy);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({busy, done, product} !== {1'b0, 1'b0, 16'd0})
            $display("FAIL abort_reset_state: got busy=%b done=%b product=%0d, want 0/0/0",
                     busy, done, product);
        else n_pass++;
        seen_done = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        n_total++;
        if (seen_done !== 1'b0) $display("FAIL abort_no_done: got activity=%b, want 0", seen_done);
        else n_pass++;
        do_mul(8'd2, 8'd3, lat, nbusy, both, res);
        n_total++;
        if (res !== 16'd6 || lat !== SIZE + 1)
            $display("FAIL abort_restart: got product=%0d lat=%0d, want 6 lat=%0d", res, lat, SIZE + 1);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat, nbusy;
        bit both;
        logic [15:0] res;
        logic [7:0]  ra, rb;
        logic [15:0] exp_p;
        for (int i = 0; i < 1000; i++) begin
            ra    = 8'($urandom_range(0, 255));
            rb    = 8'($urandom_range(0, 255));
            exp_p = 16'(ra) * 16'(rb);
            do_mul(ra, rb, lat, nbusy, both, res);
            n_total++;
            if (res !== exp_p)
                $display("FAIL rand_product %0dx%0d: got %0d, want %0d", ra, rb, res, exp_p);
            else n_pass++;
            n_total++;
            if (lat !== SIZE + 1 || nbusy !== SIZE)
                $display("FAIL rand_latency %0dx%0d: got lat=%0d busy=%0d, want %0d/%0d",
                         ra, rb, lat, nbusy, SIZE + 1, SIZE);
            else n_pass++;
            n_total++;
            if (both !== 1'b0) $display("FAIL rand_overlap %0dx%0d: got %b, want 0", ra, rb, both);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
